// File: rtl/tmds_period_scheduler_if.sv
// Pixel-side bundle between the timing generator, the period scheduler and the
// three TMDS encoders.
//   in_de / in_hsync / in_vsync / in_rgb : raw timing-generator stream
//   out_mode   : encoder mode (0 CTRL, 1 PREAMBLE, 2 GUARD, 3 VIDEO)
//   out_ctl    : CTL3..CTL0 for the encoders
//   out_hsync / out_vsync / out_rgb : re-timed stream toward the encoders
//   err_short_blank : one-cycle pulse, blanking too short for a preamble
// slave  = scheduler side, master = source/sink side (testbench or top level).
interface tmds_period_scheduler_if #(
  parameter int DW = 24
) ();
  logic          in_de;
  logic          in_hsync;
  logic          in_vsync;
  logic [DW-1:0] in_rgb;
  logic [1:0]    out_mode;
  logic [3:0]    out_ctl;
  logic          out_hsync;
  logic          out_vsync;
  logic [DW-1:0] out_rgb;
  logic          err_short_blank;

  modport slave (
    input  in_de, in_hsync, in_vsync, in_rgb,
    output out_mode, out_ctl, out_hsync, out_vsync, out_rgb, err_short_blank
  );

  modport master (
    output in_de, in_hsync, in_vsync, in_rgb,
    input  out_mode, out_ctl, out_hsync, out_vsync, out_rgb, err_short_blank
  );
endinterface

// File: rtl/tmds_period_scheduler.sv
// Per-pixel sequencer for the HDMI TMDS encoders. The input stream is delayed by
// LATENCY cycles so the video preamble and leading guard band fit in front of
// every active run; with hdmi_en=0 the output only alternates CTRL/VIDEO (DVI).
// Ports:
//   pixel_clk : sole clock
//   rst       : synchronous reset, active-high
//   hdmi_en   : 1 inserts preamble/guard, sampled only at a de rise
//   bus       : slave side of tmds_period_scheduler_if (stream in, encoder controls out)
//
// state    | meaning
// CTRL     | blanking, control symbols (out_mode 0)
// PREAMBLE | video preamble, CTL=0001 (out_mode 1)
// GUARD    | leading video guard band (out_mode 2)
// VIDEO    | active pixels (out_mode 3)
module tmds_period_scheduler #(
  parameter int DW           = 24,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2,
  parameter int CTRL_MIN     = 4
) (
  input  logic pixel_clk,
  input  logic rst,
  input  logic hdmi_en,
  tmds_period_scheduler_if.slave bus
);
  localparam int LATENCY = PREAMBLE_LEN + GUARD_LEN + 1;
  localparam int THR     = LATENCY + CTRL_MIN;
  localparam int BW      = $clog2(THR + 1);
  localparam int CW      = $clog2(PREAMBLE_LEN + GUARD_LEN + 1);

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] phase_cnt, phase_cnt_nx;

  // Stage i holds the input sampled i edges ago; stage LATENCY drives the outputs.
  logic [LATENCY-1:0] de_dl;
  logic [LATENCY:0]   hs_dl;
  logic [LATENCY:0]   vs_dl;
  logic [DW-1:0]      rgb_dl [LATENCY+1];

  logic [BW-1:0] blank_cnt;
  logic          rise;
  logic          blank_ok;
  logic          qual_rise;
  logic          short_rise;
  logic          err_q;

  // de_dl[0] is the de of the previous edge, so this is a rise at the current edge.
  assign rise     = bus.in_de & ~de_dl[0];
  // blank_cnt here is the pre-edge value, as needed for qualification.
  assign blank_ok = (blank_cnt >= BW'(THR));

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      de_dl      <= '0;
      hs_dl      <= '0;
      vs_dl      <= '0;
      for (int i = 0; i <= LATENCY; i++) rgb_dl[i] <= '0;
      blank_cnt  <= '0;
      qual_rise  <= 1'b0;
      short_rise <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      de_dl     <= {de_dl[LATENCY-2:0], bus.in_de};
      hs_dl     <= {hs_dl[LATENCY-1:0], bus.in_hsync};
      vs_dl     <= {vs_dl[LATENCY-1:0], bus.in_vsync};
      rgb_dl[0] <= bus.in_rgb;
      for (int i = 1; i <= LATENCY; i++) rgb_dl[i] <= rgb_dl[i-1];

      if (bus.in_de)
        blank_cnt <= '0;
      else if (blank_cnt != BW'(THR))
        blank_cnt <= blank_cnt + BW'(1);

      // hdmi_en is only looked at here, so mid-line toggles have no effect.
      qual_rise  <= rise & hdmi_en & blank_ok;
      short_rise <= rise & hdmi_en & ~blank_ok;
      err_q      <= short_rise;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state     <= CTRL;
      phase_cnt <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_cnt_nx;
    end
  end

  // de_dl[LATENCY-1] is the de that reaches the outputs on the coming edge, so
  // CTRL/VIDEO switches line up with the delayed pixels.
  always_comb begin
    state_nx     = state;
    phase_cnt_nx = phase_cnt;
    case (state)
      CTRL: begin
        if (qual_rise) begin
          state_nx     = PREAMBLE;
          phase_cnt_nx = CW'(PREAMBLE_LEN - 1);
        end else if (de_dl[LATENCY-1]) begin
          state_nx = VIDEO;
        end
      end
      PREAMBLE: begin
        if (phase_cnt == '0) begin
          state_nx     = GUARD;
          phase_cnt_nx = CW'(GUARD_LEN - 1);
        end else begin
          phase_cnt_nx = phase_cnt - CW'(1);
        end
      end
      GUARD: begin
        if (phase_cnt == '0)
          state_nx = VIDEO;
        else
          phase_cnt_nx = phase_cnt - CW'(1);
      end
      VIDEO: begin
        if (!de_dl[LATENCY-1]) state_nx = CTRL;
      end
      default: state_nx = CTRL;
    endcase
  end

  assign bus.out_mode        = state;
  assign bus.out_ctl         = (state == PREAMBLE) ? 4'b0001 : 4'b0000;
  assign bus.out_hsync       = hs_dl[LATENCY];
  assign bus.out_vsync       = vs_dl[LATENCY];
  assign bus.out_rgb         = (state == VIDEO) ? rgb_dl[LATENCY] : '0;
  assign bus.err_short_blank = err_q;
endmodule
